core_mem_arbiter: RTL

//  Shares one single-ported memory bus between the Core instruction port (fetch) and data port (load/store).

---
 rtl/core_mem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// Arbitrates one single-ported memory bus between the core fetch and load/store ports.
// One outstanding transaction, bounded data priority, fetch flush draining and bus timeout.
module core_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    input  logic        instr_flush_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rsp_o,
    output logic [31:0] instr_data_o,
    input  logic        data_rd_i,
    input  logic        data_wr_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rsp_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rsp_i,
    input  logic [31:0] mem_rdata_i,
    output logic        bus_error_o
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TO_LAST =
        TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = TIMEOUT_CYCLES > 0;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INSTR,
        DRAIN,
        RESP
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] streak, streak_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          rd_q, rd_n;
    logic          wr_q, wr_n;
    logic [31:0]   addr_q, addr_n;
    logic [31:0]   wdata_q, wdata_n;
    logic          irsp_q, irsp_n;
    logic          drsp_q, drsp_n;
    logic [31:0]   idata_q, idata_n;
    logic [31:0]   ddata_q, ddata_n;
    logic          berr_q, berr_n;

    logic fetch_pend;
    logic data_req;
    logic data_win;
    logic expired;

    assign fetch_pend = instr_req_i && !instr_flush_i;
    assign data_req   = data_rd_i || data_wr_i;
    assign data_win   = data_req && !(fetch_pend && streak == STREAK_MAX);
    assign expired    = TO_EN && (tcnt == TO_LAST) && !mem_rsp_i;

    // tcnt defaults to zero so it clears on every state change
    always_comb begin
        state_n  = state;
        streak_n = streak;
        tcnt_n   = '0;
        rd_n     = rd_q;
        wr_n     = wr_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        irsp_n   = 1'b0;
        drsp_n   = 1'b0;
        idata_n  = idata_q;
        ddata_n  = ddata_q;
        berr_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (data_win) begin
                    state_n = DATA;
                    wr_n    = data_wr_i;
                    rd_n    = !data_wr_i;
                    addr_n  = data_addr_i;
                    wdata_n = data_wdata_i;
                    if (!fetch_pend)
                        streak_n = '0;
                    else if (streak != STREAK_MAX)
                        streak_n = streak + SW'(1);
                end else if (fetch_pend) begin
                    state_n  = INSTR;
                    rd_n     = 1'b1;
                    wr_n     = 1'b0;
                    addr_n   = instr_addr_i;
                    streak_n = '0;
                end
            end
            DATA: begin
                if (mem_rsp_i || expired) begin
                    state_n = RESP;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    drsp_n  = 1'b1;
                    berr_n  = !mem_rsp_i;
                    ddata_n = mem_rsp_i ? mem_rdata_i : 32'h0;
                end else if (TO_EN) begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            INSTR: begin
                if (instr_flush_i) begin
                    // the slave cannot be cancelled, so wait out its reply
                    state_n = mem_rsp_i ? IDLE : DRAIN;
                    rd_n    = !mem_rsp_i;
                end else if (mem_rsp_i || expired) begin
                    state_n = RESP;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    irsp_n  = 1'b1;
                    berr_n  = !mem_rsp_i;
                    idata_n = mem_rsp_i ? mem_rdata_i : 32'h0;
                end else if (TO_EN) begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            DRAIN: begin
                if (mem_rsp_i || expired) begin
                    state_n = IDLE;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    berr_n  = !mem_rsp_i;
                end else if (TO_EN) begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            streak  <= '0;
            tcnt    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            irsp_q  <= 1'b0;
            drsp_q  <= 1'b0;
            idata_q <= '0;
            ddata_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            streak  <= streak_n;
            tcnt    <= tcnt_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            irsp_q  <= irsp_n;
            drsp_q  <= drsp_n;
            idata_q <= idata_n;
            ddata_q <= ddata_n;
            berr_q  <= berr_n;
        end
    end

    assign mem_rd_o     = rd_q;
    assign mem_wr_o     = wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign instr_rsp_o  = irsp_q;
    assign instr_data_o = idata_q;
    assign data_rsp_o   = drsp_q;
    assign data_rdata_o = ddata_q;
    assign bus_error_o  = berr_q;

endmodule
